// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the matrix-keypad scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        SCAN     = 3'd2,
        DECIDE   = 3'd3,
        HELD     = 3'd4,
        DB_REL   = 3'd5,
        WAIT_REL = 3'd6
    } kp_state_e;

    // Width of the linear key code row*COLS+col.
    function automatic int key_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_val without wrapping.
    function automatic int cnt_w(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

    // Width of an index into n items.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_matrix_scan_if.sv
// Pin-side and event-side signals of the keypad scanner, bundled as one port.
interface keypad_matrix_scan_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    import keypad_pkg::*;

    localparam int KEY_W = key_w(ROWS, COLS);

    logic [ROWS-1:0]  row_data;
    logic [COLS-1:0]  col_data;
    logic             repeat_en;
    logic [KEY_W-1:0] key_code;
    logic             key_press;
    logic             key_repeat;
    logic             key_release;
    logic             key_held;
    logic             multi_err;

    // Keypad/host side: drives rows and repeat enable, consumes events.
    modport master (
        output row_data,
        output repeat_en,
        input  col_data,
        input  key_code,
        input  key_press,
        input  key_repeat,
        input  key_release,
        input  key_held,
        input  multi_err
    );

    // Scanner side.
    modport slave (
        input  row_data,
        input  repeat_en,
        output col_data,
        output key_code,
        output key_press,
        output key_repeat,
        output key_release,
        output key_held,
        output multi_err
    );

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad rows.
module keypad_row_sync #(
    parameter int ROWS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row_i,
    output logic [ROWS-1:0] row_o
);

    logic [ROWS-1:0] meta_q;
    logic [ROWS-1:0] sync_q;

    // Reset to all-ones so the scanner sees "no key" until real rows arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= row_i;
            sync_q <= meta_q;
        end
    end

    assign row_o = sync_q;

endmodule

// File: rtl/keypad_matrix_scan.sv
// Parametrised ROWS x COLS keypad scanner: debounce, column scan, single-key
// decode with multi-key rejection, auto-repeat and debounced release.
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int DEBOUNCE_CYC    = 1_000_000,
    parameter int SETTLE_CYC      = 3,
    parameter int REPEAT_DLY_CYC  = 25_000_000,
    parameter int REPEAT_RATE_CYC = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    keypad_matrix_scan_if.slave  kp
);

    localparam int KEY_W  = key_w(ROWS, COLS);
    localparam int ROW_W  = idx_w(ROWS);
    localparam int COL_W  = idx_w(COLS);
    localparam int NL_W   = cnt_w(ROWS * COLS);
    localparam int DB_W   = cnt_w(DEBOUNCE_CYC);
    localparam int ST_W   = cnt_w(SETTLE_CYC);
    localparam int RP_MAX = (REPEAT_DLY_CYC > REPEAT_RATE_CYC) ? REPEAT_DLY_CYC : REPEAT_RATE_CYC;
    localparam int RP_W   = cnt_w(RP_MAX);

    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [ST_W-1:0]  ST_LAST      = ST_W'(SETTLE_CYC);
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(COLS - 1);
    localparam logic [NL_W-1:0]  NL_MAX       = NL_W'(ROWS * COLS);
    localparam logic [RP_W-1:0]  RP_DLY_LAST  = RP_W'(REPEAT_DLY_CYC - 1);
    localparam logic [RP_W-1:0]  RP_RATE_LAST = RP_W'(REPEAT_RATE_CYC - 1);

    // Number of active (low) rows in one sample.
    function automatic logic [NL_W-1:0] count_low(input logic [ROWS-1:0] rows);
        logic [NL_W-1:0] n;
        n = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (!rows[i]) n = n + NL_W'(1);
        end
        return n;
    endfunction

    // Lowest-numbered active row.
    function automatic logic [ROW_W-1:0] first_low(input logic [ROWS-1:0] rows);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = ROW_W'(i);
        end
        return idx;
    endfunction

    // Running key count that clamps at the matrix size.
    function automatic logic [NL_W-1:0] sat_add_low(input logic [NL_W-1:0] a,
                                                     input logic [NL_W-1:0] b);
        logic [NL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, NL_MAX}) return NL_MAX;
        return s[NL_W-1:0];
    endfunction

    function automatic logic [KEY_W-1:0] encode_key(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return KEY_W'(int'(r) * COLS + int'(c));
    endfunction

    logic [ROWS-1:0] rs;

    kp_state_e        state_q,     state_d;
    logic [DB_W-1:0]  db_cnt_q,    db_cnt_d;
    logic [ST_W-1:0]  st_cnt_q,    st_cnt_d;
    logic [COL_W-1:0] col_idx_q,   col_idx_d;
    logic [RP_W-1:0]  rep_cnt_q,   rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic [KEY_W-1:0] key_code_q,  key_code_d;
    logic             press_q,     press_d;
    logic             repeat_q,    repeat_d;
    logic             release_q,   release_d;
    logic             multi_q,     multi_d;

    logic [NL_W-1:0]  nlow_q,      nlow_d;
    logic             found_q,     found_d;
    logic [ROW_W-1:0] frow_q,      frow_d;
    logic [COL_W-1:0] fcol_q,      fcol_d;
    logic [ROW_W-1:0] krow_q,      krow_d;
    logic [COL_W-1:0] kcol_q,      kcol_d;

    logic             rs_idle;
    logic             key_row_hi;
    logic [NL_W-1:0]  low_cnt;
    logic [RP_W-1:0]  rep_last;
    logic [COLS-1:0]  col_drive;

    keypad_row_sync #(.ROWS(ROWS)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .row_i (kp.row_data),
        .row_o (rs)
    );

    assign rs_idle    = &rs;
    assign key_row_hi = rs[krow_q];
    assign low_cnt    = count_low(rs);
    assign rep_last   = rep_first_q ? RP_RATE_LAST : RP_DLY_LAST;

    // Next-state, counters and event pulses.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        st_cnt_d    = st_cnt_q;
        col_idx_d   = col_idx_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        key_code_d  = key_code_q;
        press_d     = 1'b0;
        repeat_d    = 1'b0;
        release_d   = 1'b0;
        multi_d     = 1'b0;
        nlow_d      = nlow_q;
        found_d     = found_q;
        frow_d      = frow_q;
        fcol_d      = fcol_q;
        krow_d      = krow_q;
        kcol_d      = kcol_q;

        case (state_q)
            IDLE: begin
                if (!rs_idle) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = '0;
                end
            end

            DB_PRESS: begin
                if (rs_idle) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d   = SCAN;
                    db_cnt_d  = '0;
                    col_idx_d = '0;
                    st_cnt_d  = '0;
                    nlow_d    = '0;
                    found_d   = 1'b0;
                    frow_d    = '0;
                    fcol_d    = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            SCAN: begin
                if (st_cnt_q < ST_LAST) begin
                    st_cnt_d = st_cnt_q + ST_W'(1);
                end else begin
                    st_cnt_d = '0;
                    nlow_d   = sat_add_low(nlow_q, low_cnt);
                    if (!found_q && (low_cnt != '0)) begin
                        found_d = 1'b1;
                        frow_d  = first_low(rs);
                        fcol_d  = col_idx_q;
                    end
                    if (col_idx_q == COL_LAST) begin
                        state_d = DECIDE;
                    end else begin
                        col_idx_d = col_idx_q + COL_W'(1);
                    end
                end
            end

            DECIDE: begin
                // st_cnt doubles as a settle blank for the held column.
                st_cnt_d = '0;
                if (nlow_q == '0) begin
                    state_d = IDLE;
                end else if (nlow_q == NL_W'(1)) begin
                    state_d     = HELD;
                    key_code_d  = encode_key(frow_q, fcol_q);
                    krow_d      = frow_q;
                    kcol_d      = fcol_q;
                    press_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    state_d  = WAIT_REL;
                    multi_d  = 1'b1;
                    db_cnt_d = '0;
                end
            end

            HELD: begin
                if (st_cnt_q < ST_LAST) st_cnt_d = st_cnt_q + ST_W'(1);
                if ((st_cnt_q >= ST_LAST) && key_row_hi) begin
                    state_d  = DB_REL;
                    db_cnt_d = DB_W'(1);
                end else if (!kp.repeat_en) begin
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else if (rep_cnt_q >= rep_last) begin
                    repeat_d    = 1'b1;
                    rep_first_d = 1'b1;
                    rep_cnt_d   = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + RP_W'(1);
                end
            end

            DB_REL: begin
                // Repeat counter is frozen here and resumes on return to HELD.
                if (!key_row_hi) begin
                    state_d  = HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    db_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            WAIT_REL: begin
                if (!rs_idle) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Column drive: one column during scan and hold, all columns otherwise.
    always_comb begin
        col_drive = '0;
        case (state_q)
            SCAN: begin
                col_drive            = '1;
                col_drive[col_idx_q] = 1'b0;
            end
            HELD, DB_REL: begin
                col_drive         = '1;
                col_drive[kcol_q] = 1'b0;
            end
            default: col_drive = '0;
        endcase
    end

    // Control state, counters, key code and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            st_cnt_q    <= '0;
            col_idx_q   <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
            key_code_q  <= '0;
            press_q     <= 1'b0;
            repeat_q    <= 1'b0;
            release_q   <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            st_cnt_q    <= st_cnt_d;
            col_idx_q   <= col_idx_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            key_code_q  <= key_code_d;
            press_q     <= press_d;
            repeat_q    <= repeat_d;
            release_q   <= release_d;
            multi_q     <= multi_d;
        end
    end

    // Scan accumulators and captured key position; always loaded before use.
    always_ff @(posedge clk) begin
        nlow_q  <= nlow_d;
        found_q <= found_d;
        frow_q  <= frow_d;
        fcol_q  <= fcol_d;
        krow_q  <= krow_d;
        kcol_q  <= kcol_d;
    end

    assign kp.col_data    = col_drive;
    assign kp.key_code    = key_code_q;
    assign kp.key_press   = press_q;
    assign kp.key_repeat  = repeat_q;
    assign kp.key_release = release_q;
    assign kp.multi_err   = multi_q;
    assign kp.key_held    = (state_q == HELD) || (state_q == DB_REL);

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Self-checking bench for keypad_matrix_scan with a behavioural keypad and
// an event-timing reference model.
module tb_keypad_matrix_scan;

    localparam int ROWS_T = 4;
    localparam int COLS_T = 4;

    logic clk;
    logic rst;
    logic [ROWS_T*COLS_T-1:0] pressed;
    logic [ROWS_T-1:0]        row_v;

    int cyc;
    int n_chk;
    int n_err;
    logic rst_d;
    int   prev_code;
    int   np;

    int ev_press[$];
    int ev_code[$];
    int ev_rep[$];
    int ev_rel[$];
    int ev_multi[$];

    keypad_matrix_scan_if #(.ROWS(ROWS_T), .COLS(COLS_T)) kp ();

    keypad_matrix_scan #(
        .ROWS            (ROWS_T),
        .COLS            (COLS_T),
        .DEBOUNCE_CYC    (16),
        .SETTLE_CYC      (3),
        .REPEAT_DLY_CYC  (64),
        .REPEAT_RATE_CYC (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive switch matrix: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        row_v = '1;
        for (int r = 0; r < ROWS_T; r++) begin
            for (int c = 0; c < COLS_T; c++) begin
                if (pressed[r*COLS_T+c] && !kp.col_data[c]) row_v[r] = 1'b0;
            end
        end
    end
    assign kp.row_data = row_v;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Event logger plus per-cycle exclusivity and key-code stability.
    always @(negedge clk) begin
        if (kp.key_press) begin
            ev_press.push_back(cyc);
            ev_code.push_back(int'(kp.key_code));
        end
        if (kp.key_repeat)  ev_rep.push_back(cyc);
        if (kp.key_release) ev_rel.push_back(cyc);
        if (kp.multi_err)   ev_multi.push_back(cyc);
        np = int'(kp.key_press) + int'(kp.key_repeat) + int'(kp.key_release) + int'(kp.multi_err);
        if (!rst && !rst_d) begin
            check_eq("pulse_excl", int'(np <= 1), 1);
            if (!kp.key_press) check_eq("code_stable", int'(kp.key_code), prev_code);
        end
        prev_code = int'(kp.key_code);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_events();
        ev_press.delete();
        ev_code.delete();
        ev_rep.delete();
        ev_rel.delete();
        ev_multi.delete();
    endtask

    // One key pressed, held `hold` cycles after key_press, then released.
    task automatic single_key(input int r, input int c, input bit rep, input int hold);
        int t_in, p, bad, lat, t_rel;
        int exp_rep[$];
        clear_events();
        kp.repeat_en = rep;
        pressed = '0;
        pressed[r*COLS_T+c] = 1'b1;
        t_in = cyc;
        wait_cyc(45);
        check_eq("press_cnt", ev_press.size(), 1);
        p = (ev_press.size() > 0) ? ev_press[0] : t_in + 36;
        lat = p - t_in;
        check_eq("press_lat_in_window", int'(lat >= 34 && lat <= 38), 1);
        check_eq("press_code", (ev_code.size() > 0) ? ev_code[0] : -1, r*COLS_T + c);
        bad = 0;
        while (cyc < p + hold) begin
            bad += kp.key_held ? 0 : 1;
            @(negedge clk);
        end
        check_eq("held_cycles_low", bad, 0);
        pressed = '0;
        t_rel = cyc;
        wait_cyc(30);
        check_eq("release_cnt", ev_rel.size(), 1);
        lat = (ev_rel.size() > 0) ? ev_rel[0] - t_rel : -1;
        check_eq("release_lat_in_window", int'(lat >= 16 && lat <= 20), 1);
        exp_rep = {};
        if (rep) begin
            for (int k = 64; k < hold; k += 16) exp_rep.push_back(k);
        end
        check_eq("repeat_cnt", ev_rep.size(), exp_rep.size());
        for (int i = 0; i < exp_rep.size() && i < ev_rep.size(); i++) begin
            check_eq("repeat_offset", ev_rep[i] - p, exp_rep[i]);
        end
        check_eq("multi_cnt", ev_multi.size(), 0);
        check_eq("held_after_release", int'(kp.key_held), 0);
        kp.repeat_en = 1'b0;
    endtask

    // Two distinct keys together must give exactly one multi_err and no press.
    task automatic two_keys(input int k0, input int k1);
        int t_in, lat, code_before;
        clear_events();
        code_before = int'(kp.key_code);
        pressed = '0;
        pressed[k0] = 1'b1;
        pressed[k1] = 1'b1;
        t_in = cyc;
        wait_cyc(45);
        check_eq("multi_cnt", ev_multi.size(), 1);
        lat = (ev_multi.size() > 0) ? ev_multi[0] - t_in : -1;
        check_eq("multi_lat_in_window", int'(lat >= 34 && lat <= 38), 1);
        check_eq("multi_no_press", ev_press.size(), 0);
        check_eq("multi_code_kept", int'(kp.key_code), code_before);
        pressed = '0;
        wait_cyc(40);
        check_eq("multi_no_release", ev_rel.size(), 0);
    endtask

    initial begin
        int r, c, h, k0, k1, bad, t_rel, lat;
        bit rep;
        cyc = 0;
        n_chk = 0;
        n_err = 0;
        prev_code = 0;
        rst = 1'b1;
        pressed = '0;
        kp.repeat_en = 1'b0;
        clear_events();
        repeat (4) @(negedge clk);
        check_eq("rst_col_data", int'(kp.col_data), 0);
        check_eq("rst_key_code", int'(kp.key_code), 0);
        check_eq("rst_key_held", int'(kp.key_held), 0);
        check_eq("rst_pulses", int'({kp.key_press, kp.key_repeat, kp.key_release, kp.multi_err}), 0);
        rst = 1'b0;
        wait_cyc(5);

        // Row 2 / col 1, no repeat, long hold.
        single_key(2, 1, 1'b0, 200);
        wait_cyc(20);
        // Same key with auto-repeat.
        single_key(2, 1, 1'b1, 150);
        wait_cyc(20);

        // Contact bounce never stays low long enough to debounce.
        clear_events();
        for (int i = 0; i < 5; i++) begin
            pressed = '0;
            pressed[5] = 1'b1;
            wait_cyc(5);
            pressed = '0;
            wait_cyc(3);
        end
        wait_cyc(40);
        check_eq("bounce_events", ev_press.size() + ev_rel.size() + ev_rep.size() + ev_multi.size(), 0);
        check_eq("bounce_idle_cols", int'(kp.col_data), 0);
        check_eq("bounce_idle_held", int'(kp.key_held), 0);

        // Two keys in column 2, then a clean press of key 0.
        two_keys(0*COLS_T + 2, 3*COLS_T + 2);
        single_key(0, 0, 1'b0, 72);
        wait_cyc(20);

        // Random single keys with random repeat and hold length.
        for (int t = 0; t < 5; t++) begin
            r   = $urandom_range(0, ROWS_T - 1);
            c   = $urandom_range(0, COLS_T - 1);
            rep = 1'($urandom_range(0, 1));
            h   = 72 + 16 * $urandom_range(0, 3);
            single_key(r, c, rep, h);
            wait_cyc(10);
        end

        // Random two-key combinations.
        for (int t = 0; t < 3; t++) begin
            k0 = $urandom_range(0, ROWS_T*COLS_T - 1);
            k1 = (k0 + 1 + $urandom_range(0, ROWS_T*COLS_T - 2)) % (ROWS_T*COLS_T);
            two_keys(k0, k1);
        end

        // Release glitch on key 15 must not produce a release.
        clear_events();
        pressed = '0;
        pressed[15] = 1'b1;
        wait_cyc(45);
        check_eq("glitch_press_cnt", ev_press.size(), 1);
        check_eq("glitch_press_code", (ev_code.size() > 0) ? ev_code[0] : -1, 15);
        wait_cyc(30);
        bad = 0;
        pressed = '0;
        for (int i = 0; i < 8; i++) begin
            bad += kp.key_held ? 0 : 1;
            @(negedge clk);
        end
        pressed[15] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bad += kp.key_held ? 0 : 1;
            @(negedge clk);
        end
        check_eq("glitch_held_low", bad, 0);
        check_eq("glitch_no_release", ev_rel.size(), 0);
        pressed = '0;
        t_rel = cyc;
        wait_cyc(30);
        check_eq("glitch_final_release", ev_rel.size(), 1);
        lat = (ev_rel.size() > 0) ? ev_rel[0] - t_rel : -1;
        check_eq("glitch_release_lat", int'(lat >= 16 && lat <= 20), 1);

        // Reset while holding key 9.
        clear_events();
        pressed = '0;
        pressed[9] = 1'b1;
        wait_cyc(45);
        check_eq("rsthold_code", int'(kp.key_code), 9);
        wait_cyc(20);
        check_eq("rsthold_held", int'(kp.key_held), 1);
        rst = 1'b1;
        pressed = '0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_col_data", int'(kp.col_data), 0);
        check_eq("midrst_key_held", int'(kp.key_held), 0);
        check_eq("midrst_key_code", int'(kp.key_code), 0);
        check_eq("midrst_release", int'(kp.key_release), 0);
        wait_cyc(30);
        check_eq("midrst_no_release", ev_rel.size(), 0);
        check_eq("midrst_no_press", ev_press.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
